// File: rtl/dec_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : dec_issue_stage
// Purpose  : Decode/issue pipeline stage with a register scoreboard.
//            Holds back instructions that hit RAW/WAW hazards on outstanding
//            writes. Forwards same-cycle writeback data into the issued
//            operands. Provides a one-entry output register with a
//            valid/ready handshake and a saturating hazard-stall counter.
// Ports    : clk, rst (async, active-low)
//            in_valid/in_ready, in_pc, in_src1, in_src2, in_dest, in_wb
//            rf_src1/rf_src2 -> register file, rf_reg1/rf_reg2 <- data
//            wb_en, wb_dest, wb_val    writeback from later stages
//            out_valid/out_ready, out_pc, out_op1, out_op2, out_dest, out_wb
//            flush, stall_cnt
// Revision : 1.0 - initial release
// ============================================================================
module dec_issue_stage #(
   parameter int XLEN = 32,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [4:0]      in_src1,
   input  logic [4:0]      in_src2,
   input  logic [4:0]      in_dest,
   input  logic            in_wb,
   output logic [4:0]      rf_src1,
   output logic [4:0]      rf_src2,
   input  logic [XLEN-1:0] rf_reg1,
   input  logic [XLEN-1:0] rf_reg2,
   input  logic            wb_en,
   input  logic [4:0]      wb_dest,
   input  logic [XLEN-1:0] wb_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_op1,
   output logic [XLEN-1:0] out_op2,
   output logic [4:0]      out_dest,
   output logic            out_wb,
   input  logic            flush,
   output logic [CNTW-1:0] stall_cnt
);

   logic [31:0] r_pend;
   logic [31:0] w_pend_nxt;
   logic        w_byp1;
   logic        w_byp2;
   logic        w_raw;
   logic        w_waw;
   logic        w_hazard;
   logic        w_issue;

   assign rf_src1 = in_src1;
   assign rf_src2 = in_src2;

   // A writeback landing this cycle satisfies a RAW dependency because its
   // data is forwarded straight into the operand register.
   assign w_byp1 = wb_en & (wb_dest == in_src1);
   assign w_byp2 = wb_en & (wb_dest == in_src2);

   assign w_raw = in_valid & ((r_pend[in_src1] & ~w_byp1) |
                              (r_pend[in_src2] & ~w_byp2));
   // WAW is not lifted by a same-cycle writeback: the outstanding write must
   // retire before a new writer to the same index can be tracked.
   assign w_waw    = in_valid & in_wb & r_pend[in_dest];
   assign w_hazard = w_raw | w_waw;

   assign in_ready = (~out_valid | out_ready) & ~w_hazard & ~flush;
   assign w_issue  = in_valid & in_ready;

   // Clear on writeback first, then set on issue, so a set to the same index
   // takes priority.
   always_comb begin
      w_pend_nxt = r_pend;
      if (wb_en) begin
         w_pend_nxt[wb_dest] = 1'b0;
      end
      if (w_issue & in_wb) begin
         w_pend_nxt[in_dest] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend <= '0;
      end else if (flush) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   // Output register: loads on issue, drains when consumed, otherwise holds.
   // Flush only kills the valid bit; payload fields keep their last values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_op1   <= '0;
         out_op2   <= '0;
         out_dest  <= '0;
         out_wb    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (w_issue) begin
         out_valid <= 1'b1;
         out_pc    <= in_pc;
         out_op1   <= w_byp1 ? wb_val : rf_reg1;
         out_op2   <= w_byp2 ? wb_val : rf_reg2;
         out_dest  <= in_dest;
         out_wb    <= in_wb;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Counts only scoreboard hazards; downstream backpressure is not a stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (w_hazard & ~flush & ~(&stall_cnt)) begin
         stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dec_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_issue_stage
// Purpose  : Directed self-checking bench for dec_issue_stage. Issued
//            instructions push their expected output into a queue; a monitor
//            pops and compares whenever the stage hands an output downstream.
//            A second instance with a 4-bit counter covers saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_issue_stage;

   localparam int XLEN = 32;
   localparam logic [31:0] RF_BASE = 32'h1000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  dest;
      logic        wb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [4:0]  in_src1 = '0;
   logic [4:0]  in_src2 = '0;
   logic [4:0]  in_dest = '0;
   logic        in_wb = 1'b0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_dest = '0;
   logic [31:0] wb_val = '0;
   logic        out_ready = 1'b1;
   logic        flush = 1'b0;

   wire         in_ready;
   wire  [4:0]  rf_src1, rf_src2;
   wire  [31:0] rf_reg1, rf_reg2;
   wire         out_valid;
   wire  [31:0] out_pc, out_op1, out_op2;
   wire  [4:0]  out_dest;
   wire         out_wb;
   wire  [15:0] stall_cnt;

   wire         s_in_ready;
   wire  [4:0]  s_rf_src1, s_rf_src2;
   wire  [31:0] s_rf_reg1, s_rf_reg2;
   wire         s_out_valid;
   wire  [31:0] s_out_pc, s_out_op1, s_out_op2;
   wire  [4:0]  s_out_dest;
   wire         s_out_wb;
   wire  [3:0]  s_stall_cnt;

   // Register file model: register r reads as RF_BASE | r.
   assign rf_reg1   = RF_BASE | {27'd0, rf_src1};
   assign rf_reg2   = RF_BASE | {27'd0, rf_src2};
   assign s_rf_reg1 = RF_BASE | {27'd0, s_rf_src1};
   assign s_rf_reg2 = RF_BASE | {27'd0, s_rf_src2};

   always #5 clk = ~clk;

   dec_issue_stage #(.XLEN(XLEN), .CNTW(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest), .in_wb(in_wb),
      .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_reg1(rf_reg1), .rf_reg2(rf_reg2),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_op1(out_op1), .out_op2(out_op2), .out_dest(out_dest), .out_wb(out_wb),
      .flush(flush), .stall_cnt(stall_cnt)
   );

   dec_issue_stage #(.XLEN(XLEN), .CNTW(4)) dut_sat (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc),
      .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest), .in_wb(in_wb),
      .rf_src1(s_rf_src1), .rf_src2(s_rf_src2), .rf_reg1(s_rf_reg1), .rf_reg2(s_rf_reg2),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
      .out_op1(s_out_op1), .out_op2(s_out_op2), .out_dest(s_out_dest), .out_wb(s_out_wb),
      .flush(flush), .stall_cnt(s_stall_cnt)
   );

   int   nchk  = 0;
   int   nfail = 0;
   exp_t expq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic v, input logic [31:0] pc, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d, input logic w);
      in_valid = v; in_pc = pc; in_src1 = s1; in_src2 = s2; in_dest = d; in_wb = w;
   endtask

   task automatic wback(input logic en, input logic [4:0] d, input logic [31:0] v);
      wb_en = en; wb_dest = d; wb_val = v;
   endtask

   task automatic expect_out(input logic [31:0] pc, input logic [31:0] o1,
                             input logic [31:0] o2, input logic [4:0] d, input logic w);
      exp_t e;
      e.pc = pc; e.op1 = o1; e.op2 = o2; e.dest = d; e.wb = w;
      expq.push_back(e);
   endtask

   // Monitor: every cycle the downstream consumes an output, compare it
   // against the oldest expected issue.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         exp_t e;
         exp_t a;
         a = '{pc: out_pc, op1: out_op1, op2: out_op2, dest: out_dest, wb: out_wb};
         nchk++;
         if (expq.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_output: got pc=%0h op1=%0h op2=%0h, expected none",
                     out_pc, out_op1, out_op2);
         end else begin
            e = expq.pop_front();
            if (a !== e) begin
               nfail++;
               $display("FAIL issued_output: got pc=%0h op1=%0h op2=%0h dest=%0d wb=%0b, expected pc=%0h op1=%0h op2=%0h dest=%0d wb=%0b",
                        a.pc, a.op1, a.op2, a.dest, a.wb, e.pc, e.op1, e.op2, e.dest, e.wb);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset with an instruction presented ----------------
      instr(1'b1, 32'h50, 5'd1, 5'd2, 5'd3, 1'b1);
      out_ready = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
      chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
      chk("rst_out_ops", {out_op1, out_op2}, 64'd0);
      chk("rst_out_dest_wb", {58'd0, out_dest, out_wb}, 64'd0);
      tick();
      instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      tick();

      // ---------------- forwarding ----------------
      instr(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1);
      expect_out(32'h100, RF_BASE | 32'd1, RF_BASE | 32'd2, 5'd3, 1'b1);
      @(negedge clk);
      chk("rf_src1_passthru", {59'd0, rf_src1}, 64'd1);
      chk("rf_src2_passthru", {59'd0, rf_src2}, 64'd2);
      chk("fwd_first_ready", {63'd0, in_ready}, 64'd1);
      tick();
      instr(1'b1, 32'h104, 5'd3, 5'd0, 5'd4, 1'b0);
      wback(1'b1, 5'd3, 32'hDEAD_BEEF);
      expect_out(32'h104, 32'hDEAD_BEEF, RF_BASE, 5'd4, 1'b0);
      @(negedge clk);
      chk("fwd_no_stall", {63'd0, in_ready}, 64'd1);
      tick();
      instr(1'b1, 32'h108, 5'd3, 5'd3, 5'd0, 1'b0);
      wback(1'b0, 5'd0, 32'h0);
      expect_out(32'h108, RF_BASE | 32'd3, RF_BASE | 32'd3, 5'd0, 1'b0);
      @(negedge clk);
      chk("fwd_pend3_cleared", {63'd0, in_ready}, 64'd1);
      chk("fwd_stall_cnt", {48'd0, stall_cnt}, 64'd0);
      tick();
      // writeback to a non-pending register is harmless
      instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      wback(1'b1, 5'd9, 32'h1234_5678);
      tick();
      wback(1'b0, 5'd0, 32'h0);

      // ---------------- RAW stall ----------------
      instr(1'b1, 32'h200, 5'd9, 5'd2, 5'd5, 1'b1);
      expect_out(32'h200, RF_BASE | 32'd9, RF_BASE | 32'd2, 5'd5, 1'b1);
      @(negedge clk);
      chk("raw_producer_ready", {63'd0, in_ready}, 64'd1);
      tick();
      instr(1'b1, 32'h204, 5'd0, 5'd5, 5'd6, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("raw_stall_%0d", i), {63'd0, in_ready}, 64'd0);
         tick();
      end
      wback(1'b1, 5'd5, 32'hCAFE_0005);
      expect_out(32'h204, RF_BASE, 32'hCAFE_0005, 5'd6, 1'b0);
      @(negedge clk);
      chk("raw_release_ready", {63'd0, in_ready}, 64'd1);
      tick();
      wback(1'b0, 5'd0, 32'h0);
      instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk("raw_stall_cnt", {48'd0, stall_cnt}, 64'd3);
      tick();

      // ---------------- WAW not lifted by same-cycle writeback ----------------
      instr(1'b1, 32'h300, 5'd1, 5'd2, 5'd8, 1'b1);
      expect_out(32'h300, RF_BASE | 32'd1, RF_BASE | 32'd2, 5'd8, 1'b1);
      tick();
      instr(1'b1, 32'h304, 5'd0, 5'd0, 5'd8, 1'b1);
      wback(1'b1, 5'd8, 32'h7777_7777);
      @(negedge clk);
      chk("waw_stall", {63'd0, in_ready}, 64'd0);
      tick();
      wback(1'b0, 5'd0, 32'h0);
      expect_out(32'h304, RF_BASE, RF_BASE, 5'd8, 1'b1);
      @(negedge clk);
      chk("waw_release", {63'd0, in_ready}, 64'd1);
      chk("waw_stall_cnt", {48'd0, stall_cnt}, 64'd4);
      tick();

      // ---------------- backpressure ----------------
      instr(1'b1, 32'h400, 5'd1, 5'd2, 5'd10, 1'b0);
      expect_out(32'h400, RF_BASE | 32'd1, RF_BASE | 32'd2, 5'd10, 1'b0);
      tick();
      out_ready = 1'b0;
      instr(1'b1, 32'h404, 5'd1, 5'd2, 5'd11, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("bp_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
         chk($sformatf("bp_hold_%0d", i), {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h400});
         chk($sformatf("bp_hold_ops_%0d", i), {out_op1, out_op2}, {RF_BASE | 32'd1, RF_BASE | 32'd2});
         chk($sformatf("bp_stall_cnt_%0d", i), {48'd0, stall_cnt}, 64'd4);
         tick();
      end
      out_ready = 1'b1;
      expect_out(32'h404, RF_BASE | 32'd1, RF_BASE | 32'd2, 5'd11, 1'b0);
      @(negedge clk);
      chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
      tick();

      // ---------------- flush (pend = r5 | r8 = 0x120) ----------------
      instr(1'b1, 32'h500, 5'd1, 5'd2, 5'd5, 1'b1);
      expect_out(32'h500, RF_BASE | 32'd1, RF_BASE | 32'd2, 5'd5, 1'b1);
      tick();
      out_ready = 1'b0;
      flush = 1'b1;
      instr(1'b1, 32'h504, 5'd5, 5'd0, 5'd0, 1'b0);
      wback(1'b1, 5'd8, 32'h0);
      @(negedge clk);
      chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      void'(expq.pop_back());
      flush = 1'b0;
      wback(1'b0, 5'd0, 32'h0);
      instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_pc_holds", {32'd0, out_pc}, {32'd0, 32'h500});
      chk("flush_stall_cnt", {48'd0, stall_cnt}, 64'd4);
      tick();
      out_ready = 1'b1;
      instr(1'b1, 32'h508, 5'd5, 5'd8, 5'd5, 1'b1);
      expect_out(32'h508, RF_BASE | 32'd5, RF_BASE | 32'd8, 5'd5, 1'b1);
      @(negedge clk);
      chk("flush_pend_cleared", {63'd0, in_ready}, 64'd1);
      tick();

      // ---------------- reset mid-backpressure ----------------
      out_ready = 1'b0;
      instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      rst = 1'b0;
      expq.delete();
      #1;
      chk("rst_async_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_async_out_pc", {32'd0, out_pc}, 64'd0);
      chk("rst_async_stall_cnt", {48'd0, stall_cnt}, 64'd0);
      tick();
      rst = 1'b1;
      out_ready = 1'b1;
      instr(1'b1, 32'h600, 5'd5, 5'd7, 5'd7, 1'b1);
      expect_out(32'h600, RF_BASE | 32'd5, RF_BASE | 32'd7, 5'd7, 1'b1);
      @(negedge clk);
      chk("rst_pend_discarded", {63'd0, in_ready}, 64'd1);
      tick();

      // ---------------- saturation: 20 hazard cycles ----------------
      instr(1'b1, 32'h604, 5'd7, 5'd0, 5'd0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("sat_stall_%0d", i), {63'd0, in_ready}, 64'd0);
         tick();
      end
      @(negedge clk);
      chk("stall_cnt_20", {48'd0, stall_cnt}, 64'd20);
      chk("stall_cnt_saturated", {60'd0, s_stall_cnt}, 64'd15);
      wback(1'b1, 5'd7, 32'h5A5A_5A5A);
      expect_out(32'h604, 32'h5A5A_5A5A, RF_BASE, 5'd0, 1'b0);
      #1;
      chk("sat_release_ready", {63'd0, in_ready}, 64'd1);
      tick();
      wback(1'b0, 5'd0, 32'h0);
      instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick(); tick();
      @(negedge clk);
      chk("sat_hold_after", {60'd0, s_stall_cnt}, 64'd15);
      chk("scoreboard_drained", 64'(expq.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
`default_nettype wire
